// File: rtl/div32_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM state encoding and the
// number of count-enabled cycles the iterative divider needs to finish.
package div32_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DIV_CYCLES = 34;

endpackage

// File: rtl/div32_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, and when both
// requesters ask at once the one that was not served last is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/div32_arbiter.sv
// Shares one iterative 32-bit signed divider between two requesters: grants
// round-robin, latches operands, runs the divider and returns the quotient.
module div32_arbiter
  import div32_arbiter_pkg::*;
#(
  parameter int DW  = 32,
  parameter int TMO = 48
) (
  input  logic          clk,
  input  logic          ctrl,
  input  logic [1:0]    req,
  input  logic [DW-1:0] dvnd0,
  input  logic [DW-1:0] dvsr0,
  input  logic [DW-1:0] dvnd1,
  input  logic [DW-1:0] dvsr1,
  output logic [1:0]    ack,
  output logic [1:0]    done,
  output logic [DW-1:0] result,
  output logic          err,
  output logic          busy,
  output logic          div_ctrl,
  output logic          div_on,
  output logic [DW-1:0] div_dvnd,
  output logic [DW-1:0] div_dvsr,
  input  logic [DW-1:0] div_res,
  input  logic          div_e,
  input  logic          div_rdy
);

  localparam int              WDW     = $clog2(TMO);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TMO - 1);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      gnt;
  logic            owner;
  logic            last;
  logic [WDW-1:0]  wdog;
  logic [DW-1:0]   sel_dvnd;
  logic [DW-1:0]   sel_dvsr;
  logic            sel_zero;

  rr_arb2 u_arb (
    .req  (req),
    .last (last),
    .gnt  (gnt)
  );

  assign sel_dvnd = gnt[1] ? dvnd1 : dvnd0;
  assign sel_dvsr = gnt[1] ? dvsr1 : dvsr0;
  assign sel_zero = (sel_dvsr == '0);

  // The divider is held cleared for the whole reset as well as in CLEAR.
  assign busy     = (state != ST_IDLE);
  assign div_ctrl = ctrl | (state == ST_CLEAR);
  assign div_on   = (state == ST_RUN);

  always_ff @(posedge clk or posedge ctrl) begin
    if (ctrl) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          state_nxt = sel_zero ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: state_nxt = ST_RUN;
      ST_RUN: begin
        if (div_rdy || (wdog == WD_LAST)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are latched only at grant, so they stay stable through CLEAR/RUN
  // even if the requester drops or changes its inputs after ack.
  always_ff @(posedge clk or posedge ctrl) begin
    if (ctrl) begin
      ack      <= '0;
      done     <= '0;
      result   <= '0;
      err      <= 1'b0;
      div_dvnd <= '0;
      div_dvsr <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      wdog     <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            ack      <= gnt;
            div_dvnd <= sel_dvnd;
            div_dvsr <= sel_dvsr;
            owner    <= gnt[1];
            last     <= gnt[1];
            if (sel_zero) begin
              result <= '0;
              err    <= 1'b1;
            end
          end
        end
        ST_CLEAR: wdog <= '0;
        ST_RUN: begin
          wdog <= wdog + 1'b1;
          if (div_rdy) begin
            result <= div_res;
            err    <= div_e;
          end else if (wdog == WD_LAST) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        ST_DONE: done <= owner ? 2'b10 : 2'b01;
        default: ;
      endcase
    end
  end

endmodule
